// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between a load/store unit and the data memory
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: two-region data memory with byte/half/word access and a 1-cycle registered response
module data_mem_responder #(
  parameter logic [31:0] STATIC_BASE  = 32'h1000_0000,
  parameter int          STATIC_WORDS = 32,
  parameter logic [31:0] DYN_BASE     = 32'h1000_8000,
  parameter int          DYN_WORDS    = 32
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);
  localparam int SAW = STATIC_WORDS > 1 ? $clog2(STATIC_WORDS) : 1;
  localparam int DAW = DYN_WORDS > 1 ? $clog2(DYN_WORDS) : 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_smem [STATIC_WORDS];
  logic [31:0] r_dmem [DYN_WORDS];
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] w_soff, w_doff, w_rword, w_sh, w_lane, w_wword, w_ld;
  logic [SAW-1:0] w_sidx;
  logic [DAW-1:0] w_didx;
  logic [3:0]  w_be;
  logic        w_hit_s, w_hit_d, w_err, w_acc;
  assign w_soff  = bus.req_addr - STATIC_BASE;
  assign w_doff  = bus.req_addr - DYN_BASE;
  assign w_hit_s = (bus.req_addr >= STATIC_BASE) && (w_soff < 32'(4 * STATIC_WORDS));
  assign w_hit_d = (bus.req_addr >= DYN_BASE) && (w_doff < 32'(4 * DYN_WORDS));
  assign w_sidx  = w_soff[SAW+1:2];
  assign w_didx  = w_doff[DAW+1:2];
  assign w_err   = !(w_hit_s || w_hit_d) || bus.req_size == 2'b11 ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign w_rword = w_hit_s ? r_smem[w_sidx] : r_dmem[w_didx];
  assign w_sh    = w_rword >> {bus.req_addr[1:0], 3'b000};
  assign w_ld    = bus.req_size == 2'b00 ? {{24{!bus.req_unsigned && w_sh[7]}}, w_sh[7:0]} :
                   bus.req_size == 2'b01 ? {{16{!bus.req_unsigned && w_sh[15]}}, w_sh[15:0]} : w_sh;
  assign w_acc   = bus.req_valid && bus.req_ready;
  assign bus.req_ready  = !rst && (r_state == IDLE || bus.resp_ready);
  assign bus.resp_valid = !rst && r_state == RESP;
  assign bus.resp_rdata = rst ? 32'h0 : r_rdata;
  assign bus.resp_err   = !rst && r_err;
  // Store merge: replicate the store data across lanes and keep unselected bytes of the current word
  always_comb begin
    w_be    = bus.req_size == 2'b00 ? 4'b0001 << bus.req_addr[1:0] :
              bus.req_size == 2'b01 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
    w_lane  = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
              bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    w_wword = w_rword;
    for (int k = 0; k < 4; k++) w_wword[8*k +: 8] = w_be[k] ? w_lane[8*k +: 8] : w_rword[8*k +: 8];
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state: a new acceptance always yields a response; a drained response returns to idle
  always_comb begin
    w_next = r_state;
    w_next = w_acc ? RESP : (r_state == RESP && bus.resp_ready) ? IDLE : r_state;
  end
  // Response capture at acceptance; stores and faults return zero data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      r_rdata <= (w_err || bus.req_we) ? 32'h0 : w_ld;
      r_err   <= w_err;
    end
  end
  // Memory: cleared on reset, written at the accepting edge of a fault-free store
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smem <= '{default: '0};
      r_dmem <= '{default: '0};
    end else if (w_acc && bus.req_we && !w_err) begin
      if (w_hit_s) r_smem[w_sidx] <= w_wword;
      else r_dmem[w_didx] <= w_wword;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data memory responder
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  data_mem_responder_if bus();
  data_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic resp(input string tag, input logic v, input logic e, input logic [31:0] d);
    chk({tag, ".valid"}, {31'b0, bus.resp_valid}, {31'b0, v});
    chk({tag, ".err"}, {31'b0, bus.resp_err}, {31'b0, e});
    chk({tag, ".rdata"}, bus.resp_rdata, d);
  endtask
  task automatic put(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_size = sz; bus.req_unsigned = u; bus.req_wdata = wd;
  endtask
  task automatic op(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [31:0] wd);
    put(we, a, sz, u, wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd0);
    resp("rst", 1'b0, 1'b0, 32'h0);
    rst = 1'b0; #1;
    chk("post_rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
    resp("post_rst", 1'b0, 1'b0, 32'h0);
    // store word then immediate load of the same word
    op(1'b1, 32'h1000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF);
    resp("sw", 1'b1, 1'b0, 32'h0);
    op(1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0);
    resp("lw", 1'b1, 1'b0, 32'hDEAD_BEEF);
    // byte store in dynamic region, signed/unsigned reloads
    op(1'b1, 32'h1000_8001, 2'b00, 1'b0, 32'h0000_0080);
    resp("sb", 1'b1, 1'b0, 32'h0);
    op(1'b0, 32'h1000_8001, 2'b00, 1'b0, 32'h0);
    resp("lb", 1'b1, 1'b0, 32'hFFFF_FF80);
    op(1'b0, 32'h1000_8001, 2'b00, 1'b1, 32'h0);
    resp("lbu", 1'b1, 1'b0, 32'h0000_0080);
    op(1'b0, 32'h1000_8000, 2'b10, 1'b0, 32'h0);
    resp("lw_dyn", 1'b1, 1'b0, 32'h0000_8000);
    // half store in the upper lane and half loads
    op(1'b1, 32'h1000_0006, 2'b01, 1'b0, 32'hFFFF_1234);
    op(1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0);
    resp("lw_half_merge", 1'b1, 1'b0, 32'h1234_BEEF);
    op(1'b0, 32'h1000_0004, 2'b01, 1'b0, 32'h0);
    resp("lh", 1'b1, 1'b0, 32'hFFFF_BEEF);
    op(1'b0, 32'h1000_0004, 2'b01, 1'b1, 32'h0);
    resp("lhu", 1'b1, 1'b0, 32'h0000_BEEF);
    // faults
    op(1'b0, 32'h1000_0080, 2'b10, 1'b0, 32'h0);
    resp("lw_past_end", 1'b1, 1'b1, 32'h0);
    op(1'b0, 32'h1000_0002, 2'b10, 1'b0, 32'h0);
    resp("lw_misalign", 1'b1, 1'b1, 32'h0);
    op(1'b0, 32'h1000_0004, 2'b11, 1'b0, 32'h0);
    resp("size11", 1'b1, 1'b1, 32'h0);
    op(1'b0, 32'h1000_0005, 2'b01, 1'b0, 32'h0);
    resp("lh_odd", 1'b1, 1'b1, 32'h0);
    op(1'b0, 32'h0FFF_FFFC, 2'b10, 1'b0, 32'h0);
    resp("below_base", 1'b1, 1'b1, 32'h0);
    op(1'b1, 32'h1000_0004, 2'b11, 1'b0, 32'h0);
    resp("sw_size11", 1'b1, 1'b1, 32'h0);
    op(1'b1, 32'h1000_0006, 2'b10, 1'b0, 32'h0);
    resp("sw_misalign", 1'b1, 1'b1, 32'h0);
    op(1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0);
    resp("unchanged", 1'b1, 1'b0, 32'h1234_BEEF);
    op(1'b1, 32'h1000_807C, 2'b10, 1'b0, 32'hA5A5_0001);
    resp("sw_dyn_last", 1'b1, 1'b0, 32'h0);
    op(1'b0, 32'h1000_807C, 2'b10, 1'b0, 32'h0);
    resp("lw_dyn_last", 1'b1, 1'b0, 32'hA5A5_0001);
    @(posedge clk); #1;
    resp("idle_drain", 1'b0, 1'b0, bus.resp_rdata);
    // backpressure: response held, conflicting store ignored
    op(1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0);
    bus.resp_ready = 1'b0;
    put(1'b1, 32'h1000_0004, 2'b10, 1'b0, 32'h1111_1111);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.req_ready", {31'b0, bus.req_ready}, 32'd0);
      resp("hold", 1'b1, 1'b0, 32'h1234_BEEF);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    put(1'b0, 32'h1000_8000, 2'b10, 1'b0, 32'h0);
    #1;
    chk("release.req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    resp("b2b", 1'b1, 1'b0, 32'h0000_8000);
    op(1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0);
    resp("ignored_store", 1'b1, 1'b0, 32'h1234_BEEF);
    // reset while a response is pending
    op(1'b1, 32'h1000_0008, 2'b10, 1'b0, 32'h0000_0005);
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    resp("mid_rst", 1'b0, 1'b0, 32'h0);
    rst = 1'b0; bus.resp_ready = 1'b1; #1;
    chk("after_rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
    resp("after_rst", 1'b0, 1'b0, 32'h0);
    op(1'b0, 32'h1000_0004, 2'b10, 1'b0, 32'h0);
    resp("cleared_s", 1'b1, 1'b0, 32'h0);
    op(1'b0, 32'h1000_8000, 2'b10, 1'b0, 32'h0);
    resp("cleared_d", 1'b1, 1'b0, 32'h0);
    op(1'b0, 32'h1000_0008, 2'b10, 1'b0, 32'h0);
    resp("cleared_s8", 1'b1, 1'b0, 32'h0);
    op(1'b0, 32'h1000_807C, 2'b10, 1'b0, 32'h0);
    resp("cleared_dlast", 1'b1, 1'b0, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter STATIC_BASE, default 32'h1000_0000, byte base address of the static data region.
REQ-002 SHALL have parameter STATIC_WORDS, default 32, static region size in 32-bit words.
REQ-003 SHALL have parameter DYN_BASE, default 32'h1000_8000, byte base address of the dynamic (gp/sp) region.
REQ-004 SHALL have parameter DYN_WORDS, default 32, dynamic region size in 32-bit words.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  in  1  request present.
REQ-008 SHALL have port req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-009 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port req_addr  in  32  byte address.
REQ-011 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-012 SHALL have port req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-013 SHALL have port req_wdata  in  32  store data, taken from the low bits.
REQ-014 SHALL have port resp_valid  out  1  response present.
REQ-015 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-016 SHALL have port resp_rdata  out  32  load result; 0 for stores and errors.
REQ-017 SHALL have port resp_err  out  1  access fault.

Function
REQ-018 SHALL implement FSM states IDLE and RESP; accepting a request moves to RESP.
REQ-019 SHALL drive req_ready = (state==IDLE) || (state==RESP && resp_ready).
REQ-020 SHALL, in RESP with resp_ready=1 and no new request, return to IDLE; with resp_ready=1 and a new request accepted, remain in RESP with the new response. Throughput is 1 transaction per cycle.
REQ-021 SHALL present resp_valid, resp_rdata and resp_err the cycle after acceptance (1-cycle latency), and hold them stable while resp_valid=1 and resp_ready=0.
REQ-022 SHALL decode a hit as STATIC_BASE <= addr < STATIC_BASE+4*STATIC_WORDS, or the same test with the DYN_* parameters. Word index = (addr-base)>>2, computed in 32-bit unsigned arithmetic with no wrap-around hit.
REQ-023 SHALL flag an error on any of: no region hit; req_size=11; half access with addr[0]=1; word access with addr[1:0]!=00.
REQ-024 SHALL, on error, leave memory unmodified and respond with resp_err=1, resp_rdata=0.
REQ-025 SHALL perform stores at the accepting clock edge, little-endian, using byte lanes selected by size and addr[1:0]; unselected bytes are unchanged.
REQ-026 SHALL perform loads by reading the word at acceptance, selecting bytes by addr[1:0], then zero- or sign-extending to 32 bits per req_unsigned.
REQ-027 SHALL make a load accepted the cycle after a store to the same word return the stored data (no stale read).
REQ-028 SHALL ignore req_* inputs while req_ready=0.

Reset
REQ-029 SHALL, while rst=1: set state to IDLE; drive resp_valid=0, resp_err=0, resp_rdata=0; clear every memory word to 0; accept no request (req_ready=0).
REQ-030 SHALL drop any pending response on reset mid-operation; the first cycle after rst falls, the block is in IDLE with req_ready=1.

Verification
REQ-031 Store word 32'hDEADBEEF @32'h1000_0004, then load word same address -> second response rdata=32'hDEADBEEF, err=0, one cycle after acceptance.
REQ-032 Store byte 8'h80 @32'h1000_8001, then load byte signed and load byte unsigned same address -> rdata 32'hFFFF_FF80, then 32'h0000_0080; loaded word = 32'h0000_8000.
REQ-033 Load word @32'h1000_0080 (one past static end), @32'h1000_0002 (misaligned), and with size=11 -> each response err=1, rdata=0, memory unchanged.
REQ-034 Hold resp_ready=0 for 3 cycles after a load -> resp_valid, rdata and err stable, req_ready=0; raise resp_ready with req_valid=1 -> back-to-back acceptance, next response the following cycle.
REQ-035 Assert rst for 1 cycle while in RESP -> resp_valid=0 next cycle; a subsequent load of any previously written word returns 0.
